// File: rtl/pipeline_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_run_ctrl_pkg
// Purpose : Shared encodings for the pipeline run/step controller.
//           - Debug command codes.
//           - Controller state type.
//           - HALT opcode value.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package pipeline_run_ctrl_pkg;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

endpackage
`default_nettype wire

// File: rtl/pipeline_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_run_ctrl_if
// Purpose : Debug-command handshake and pipeline-control bundle.
// Ports   : none. Signals:
//           - i_cmd_valid/i_cmd/o_cmd_ready: command handshake.
//           - i_halt_fetched: fetch stage holds HALT.
//           - o_valid/o_pipe_clear/o_done/o_timeout/o_n_clocks: status and control.
//           Modports: master (debug side), slave (controller).
// Rev     : 1.0  initial release
// ============================================================================
interface pipeline_run_ctrl_if #(
  parameter int NB_REG = 32
);
  logic              i_cmd_valid;
  logic [1:0]        i_cmd;
  logic              o_cmd_ready;
  logic              i_halt_fetched;
  logic              o_valid;
  logic              o_pipe_clear;
  logic              o_done;
  logic              o_timeout;
  logic [NB_REG-1:0] o_n_clocks;

  modport master (
    output i_cmd_valid, i_cmd, i_halt_fetched,
    input  o_cmd_ready, o_valid, o_pipe_clear, o_done, o_timeout, o_n_clocks
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_halt_fetched,
    output o_cmd_ready, o_valid, o_pipe_clear, o_done, o_timeout, o_n_clocks
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_run_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Up-counter that sticks at all-ones instead of wrapping.
//           Clear has priority over increment.
// Ports   : i_clock, i_reset (async, active-high)
//           i_inc  - count one on this edge
//           i_clr  - return to zero on this edge
//           o_count - current value
// Rev     : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int NB = 32
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [NB-1:0] o_count
);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_inc && (o_count != {NB{1'b1}})) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_run_ctrl
// Purpose : Run/step sequencer for the 5-stage pipeline.
//           - Drives the pipeline-wide enable.
//           - Drains the pipeline after a fetched HALT, then freezes.
//           - Counts enabled cycles.
// Ports   : i_clock, i_reset (async, active-high)
//           bus (pipeline_run_ctrl_if.slave): command handshake, halt input,
//           enable/clear/done/timeout and the enabled-cycle count.
// Options : RUNCTRL_WDOG_EN - adds a run-length watchdog. When it expires,
//           the controller enters DONE with o_timeout set.
// Rev     : 1.0  initial release
// ============================================================================
module pipeline_run_ctrl
  import pipeline_run_ctrl_pkg::*;
#(
  parameter int NB_REG       = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int MAX_CYCLES   = 1 << 20
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  pipeline_run_ctrl_if.slave     bus
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_t          state, state_nx;
  logic [DW-1:0]   drain_cnt, drain_cnt_nx;
  logic            pipe_clear_q, pipe_clear_nx;
  logic            timeout_q, timeout_nx;
  logic            valid, ready, accept, halt_seen, wdog_hit;

  assign valid     = (state == ST_RUN) || (state == ST_STEP) || (state == ST_DRAIN);
  assign ready     = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_DONE);
  assign accept    = bus.i_cmd_valid && ready;
  // Halt is only meaningful while fetching.
  // During DRAIN the fetch stage output is ignored.
  assign halt_seen = valid && bus.i_halt_fetched && (state != ST_DRAIN);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      drain_cnt    <= '0;
      pipe_clear_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state        <= state_nx;
      drain_cnt    <= drain_cnt_nx;
      pipe_clear_q <= pipe_clear_nx;
      timeout_q    <= timeout_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    drain_cnt_nx  = drain_cnt;
    pipe_clear_nx = 1'b0;
    timeout_nx    = timeout_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bus.i_cmd == CMD_RUN)       state_nx = ST_RUN;
          else if (bus.i_cmd == CMD_STEP) state_nx = ST_STEP;
        end
      end
      ST_RUN: begin
        // A halt outranks a coincident STOP, so HALT always retires.
        if (halt_seen) begin
          state_nx     = ST_DRAIN;
          drain_cnt_nx = DW'(DRAIN_CYCLES);
        end else if (wdog_hit) begin
          state_nx   = ST_DONE;
          timeout_nx = 1'b1;
        end else if (accept && (bus.i_cmd == CMD_STOP)) begin
          state_nx = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_seen) begin
          state_nx     = ST_DRAIN;
          drain_cnt_nx = DW'(DRAIN_CYCLES);
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        drain_cnt_nx = drain_cnt - 1'b1;
        if (drain_cnt <= DW'(1)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (accept && (bus.i_cmd == CMD_STOP)) begin
          state_nx      = ST_IDLE;
          pipe_clear_nx = 1'b1;
          timeout_nx    = 1'b0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Cleared on the same edge on which the clear pulse is launched.
  sat_counter #(.NB(NB_REG)) u_n_clocks (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (valid),
    .i_clr   (pipe_clear_nx),
    .o_count (bus.o_n_clocks)
  );

`ifdef RUNCTRL_WDOG_EN
  localparam int WW = $clog2(MAX_CYCLES + 1);
  logic [WW-1:0] run_len;
  logic          run_entry;

  assign run_entry = accept && (state == ST_IDLE) && (bus.i_cmd == CMD_RUN);

  sat_counter #(.NB(WW)) u_wdog (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (state == ST_RUN),
    .i_clr   (run_entry),
    .o_count (run_len)
  );

  // run_len holds the number of completed RUN cycles.
  // It reads MAX_CYCLES-1 during the final allowed cycle.
  assign wdog_hit = (state == ST_RUN) && (run_len == WW'(MAX_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  assign bus.o_valid      = valid;
  assign bus.o_cmd_ready  = ready;
  assign bus.o_done       = (state == ST_DONE);
  assign bus.o_pipe_clear = pipe_clear_q;
  assign bus.o_timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_run_ctrl
// Purpose : Self-checking bench for pipeline_run_ctrl.
//           - Stimulus pushes expected enable bursts and clear pulses into a queue.
//           - A monitor compares each burst or pulse as it completes.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pipeline_run_ctrl;
  import pipeline_run_ctrl_pkg::*;

  typedef struct {
    int    kind;   // 0 = enable burst end, 1 = clear pulse end
    int    len;
    int    n;
    int    done;
    int    tmo;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  pipeline_run_ctrl_if #(.NB_REG(32)) bus ();

  pipeline_run_ctrl #(
    .NB_REG       (32),
    .DRAIN_CYCLES (4),
    .MAX_CYCLES   (16)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int len, input int n, input int done,
                      input int tmo, input string name);
    exp_t e;
    e.kind = kind; e.len = len; e.n = n; e.done = done; e.tmo = tmo; e.name = name;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] c);
    int n = 0;
    while (!bus.o_cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.o_cmd_ready) chk("cmd_ready_wait", 0, 1);
    bus.i_cmd = c;
    bus.i_cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = CMD_NOP;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.o_done && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk(name, int'(bus.o_done), 1);
  endtask

  // Monitor: compares each completed enable burst and clear pulse.
  initial begin
    int   run = 0;
    int   clr = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_valid) begin
        run++;
      end else if (run > 0) begin
        if (q.size() == 0) begin
          chk("unexpected_burst", run, 0);
        end else begin
          e = q.pop_front();
          chk({e.name, "_kind"}, 0, e.kind);
          chk({e.name, "_len"}, run, e.len);
          chk({e.name, "_nclk"}, int'(bus.o_n_clocks), e.n);
          chk({e.name, "_done"}, int'(bus.o_done), e.done);
          chk({e.name, "_tmo"}, int'(bus.o_timeout), e.tmo);
        end
        run = 0;
      end
      if (bus.o_pipe_clear) begin
        clr++;
      end else if (clr > 0) begin
        if (q.size() == 0) begin
          chk("unexpected_clear", clr, 0);
        end else begin
          e = q.pop_front();
          chk({e.name, "_kind"}, 1, e.kind);
          chk({e.name, "_width"}, clr, e.len);
          chk({e.name, "_nclk"}, int'(bus.o_n_clocks), e.n);
          chk({e.name, "_done"}, int'(bus.o_done), e.done);
          chk({e.name, "_tmo"}, int'(bus.o_timeout), e.tmo);
        end
        clr = 0;
      end
    end
  end

  initial begin
    int bad;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = CMD_NOP;
    bus.i_halt_fetched = 1'b0;
    do_reset();

    // Reset state
    chk("rst_valid", int'(bus.o_valid), 0);
    chk("rst_done", int'(bus.o_done), 0);
    chk("rst_clear", int'(bus.o_pipe_clear), 0);
    chk("rst_tmo", int'(bus.o_timeout), 0);
    chk("rst_nclk", int'(bus.o_n_clocks), 0);
    chk("rst_ready", int'(bus.o_cmd_ready), 1);

    // 1: three single steps
    for (int i = 1; i <= 3; i++) begin
      push(0, 1, i, 0, 0, "step");
      send_cmd(CMD_STEP);
    end
    repeat (2) @(posedge clk); #1;
    chk("step_idle_ready", int'(bus.o_cmd_ready), 1);
    chk("step_idle_valid", int'(bus.o_valid), 0);
    chk("step_nclk", int'(bus.o_n_clocks), 3);

    // 2: RUN for 10 cycles, then STOP
    do_reset();
    push(0, 10, 10, 0, 0, "run_stop");
    send_cmd(CMD_RUN);
    bad = 0;
    repeat (9) begin
      if (!bus.o_cmd_ready) bad++;
      @(posedge clk); #1;
    end
    if (!bus.o_cmd_ready) bad++;
    chk("run_ready_held", bad, 0);
    send_cmd(CMD_STOP);
    repeat (3) @(posedge clk); #1;

    // 3: halt at enabled cycle 7 -> 7 + 4 enabled cycles
    do_reset();
    push(0, 11, 11, 1, 0, "halt_drain");
    send_cmd(CMD_RUN);
    repeat (6) @(posedge clk); #1;
    bus.i_halt_fetched = 1'b1;
    @(posedge clk); #1;
    bus.i_halt_fetched = 1'b0;
    wait_done("halt_done_wait");
    @(posedge clk); #1;

    // 4: RUN ignored in DONE; STOP clears
    send_cmd(CMD_RUN);
    chk("done_run_ignored", int'(bus.o_done), 1);
    chk("done_run_novalid", int'(bus.o_valid), 0);
    push(1, 1, 0, 0, 0, "stop_clear");
    send_cmd(CMD_STOP);
    repeat (2) @(posedge clk); #1;
    chk("clear_idle_ready", int'(bus.o_cmd_ready), 1);

    // 5a: halt and STOP together in RUN -> halt wins
    do_reset();
    push(0, 7, 7, 1, 0, "halt_vs_stop");
    send_cmd(CMD_RUN);
    repeat (2) @(posedge clk); #1;
    bus.i_halt_fetched = 1'b1;
    bus.i_cmd = CMD_STOP;
    bus.i_cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_halt_fetched = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = CMD_NOP;
    wait_done("halt_vs_stop_wait");
    push(1, 1, 0, 0, 0, "stop_clear2");
    send_cmd(CMD_STOP);
    repeat (2) @(posedge clk); #1;

    // 5b: reset in the middle of DRAIN
    push(0, 3, 0, 0, 0, "rst_mid_drain");
    send_cmd(CMD_RUN);
    @(posedge clk); #1;
    bus.i_halt_fetched = 1'b1;
    @(posedge clk); #1;
    bus.i_halt_fetched = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(bus.o_valid), 0);
    chk("mid_rst_done", int'(bus.o_done), 0);
    chk("mid_rst_nclk", int'(bus.o_n_clocks), 0);
    chk("mid_rst_clear", int'(bus.o_pipe_clear), 0);
    chk("mid_rst_tmo", int'(bus.o_timeout), 0);
    do_reset();

    // 6: watchdog
`ifdef RUNCTRL_WDOG_EN
    push(0, 16, 16, 1, 1, "wdog");
    send_cmd(CMD_RUN);
    wait_done("wdog_done_wait");
    @(posedge clk); #1;
    chk("wdog_tmo_sticky", int'(bus.o_timeout), 1);
    push(1, 1, 0, 0, 0, "wdog_clear");
    send_cmd(CMD_STOP);
    #1;
    chk("wdog_tmo_cleared", int'(bus.o_timeout), 0);
    repeat (2) @(posedge clk); #1;
`else
    push(0, 20, 20, 0, 0, "no_wdog");
    send_cmd(CMD_RUN);
    bad = 0;
    repeat (19) begin
      if (bus.o_timeout || !bus.o_valid) bad++;
      @(posedge clk); #1;
    end
    chk("no_wdog_run_clean", bad, 0);
    send_cmd(CMD_STOP);
    repeat (3) @(posedge clk); #1;
    chk("no_wdog_tmo", int'(bus.o_timeout), 0);
`endif

    begin
      int n = 0;
      while (q.size() != 0 && n < 30) begin
        @(posedge clk); #1; n++;
      end
      chk("queue_drained", q.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
